// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory loader.
// Provides the loader FSM state encoding and the stream framing sizes.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready handshake into the loader.
// s_valid/s_data come from the source (master), s_ready from the loader (slave).
interface imem_loader_if;
    import loader_pkg::*;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: packs accepted bytes into a 32-bit little-endian word.
// Ports: clk, reset (sync, active-low), clear, shift, byte_in -> word, word_valid.
// word is the word including the current byte_in; word_valid flags the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] sreg;
    logic [1:0]  cnt;

    // Earlier bytes drift toward bit 0, so the first byte lands in [7:0].
    assign word       = {byte_in, sreg[31:8]};
    assign word_valid = shift && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= word;
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into instmem.
// Ports: clk, reset (sync, active-low), start, s (stream slave), adr, data_in,
// WE, EN (instmem write port), core_hold, done, err (session status).
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      s,
    output logic [ADDR_W-1:0] adr,
    output logic [31:0]       data_in,
    output logic              WE,
    output logic              EN,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t                 state;
    state_t                 state_nx;
    logic [HDR_BYTES*8-1:0] count;
    logic [15:0]            count_now;
    logic [ADDR_W:0]        n_words;
    logic [ADDR_W:0]        word_idx;
    logic [7:0]             csum;
    logic                   accept;
    logic                   begin_load;
    logic                   word_valid;
    logic [31:0]            word;

    assign s.s_ready = (state == HDR0) || (state == HDR1) ||
                       (state == DATA) || (state == CSUM);
    assign accept     = s.s_valid && s.s_ready;
    assign begin_load = start && ((state == IDLE) || (state == ERR));

    assign WE        = (state == WRITE);
    assign EN        = (state == WRITE);
    assign core_hold = (state != DONE);
    assign done      = (state == DONE);
    assign err       = (state == ERR);

    // In HDR1 the high count byte is still on the bus, so use it directly.
    assign count_now = (state == HDR1) ? {s.s_data, count[7:0]} : count;
    assign n_words   = (32'(count_now) > DEPTH) ?
                       (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(count_now);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (begin_load),
        .shift     (accept && (state == DATA)),
        .byte_in   (s.s_data),
        .word      (word),
        .word_valid(word_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = HDR0;
            HDR0:    if (accept) state_nx = HDR1;
            HDR1:    if (accept) state_nx = (n_words == '0) ? CSUM : DATA;
            DATA:    if (word_valid) state_nx = WRITE;
            WRITE:   state_nx = (word_idx + (ADDR_W+1)'(1) == n_words) ?
                                CSUM : DATA;
            CSUM:    if (accept) state_nx = (s.s_data == csum) ? DONE : ERR;
            DONE:    state_nx = DONE;
            ERR:     if (start) state_nx = HDR0;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            word_idx <= '0;
            csum     <= '0;
            adr      <= '0;
            data_in  <= '0;
        end else begin
            if (begin_load) begin
                word_idx <= '0;
                csum     <= '0;
            end else if (accept && (state != CSUM)) begin
                csum <= csum ^ s.s_data;
            end
            if (accept && (state == HDR0)) count[7:0]  <= s.s_data;
            if (accept && (state == HDR1)) count[15:8] <= s.s_data;
            // Address and data are captured here and held until the next word.
            if (word_valid) begin
                adr     <= ADDR_W'(BASE_ADDR) + word_idx[ADDR_W-1:0];
                data_in <= word;
            end
            if (state == WRITE) word_idx <= word_idx + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized, model-checked bench for imem_loader.
// Two instances: 12-bit/base 0 and 2-bit/base 3 (clamp and wrap).
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [2];
    logic       start [2];
    logic       vld   [2];
    logic [7:0] sdat  [2];

    imem_loader_if if0 ();
    imem_loader_if if1 ();

    assign if0.s_valid = vld[0];
    assign if0.s_data  = sdat[0];
    assign if1.s_valid = vld[1];
    assign if1.s_data  = sdat[1];

    logic [11:0] adr0;
    logic [1:0]  adr1;
    logic [31:0] wd0, wd1;
    logic        we0, en0, hold0, done0, err0;
    logic        we1, en1, hold1, done1, err1;

    imem_loader #(.ADDR_W(12), .BASE_ADDR(0)) u0 (
        .clk(clk), .reset(rst_n[0]), .start(start[0]), .s(if0.slave),
        .adr(adr0), .data_in(wd0), .WE(we0), .EN(en0),
        .core_hold(hold0), .done(done0), .err(err0)
    );

    imem_loader #(.ADDR_W(2), .BASE_ADDR(3)) u1 (
        .clk(clk), .reset(rst_n[1]), .start(start[1]), .s(if1.slave),
        .adr(adr1), .data_in(wd1), .WE(we1), .EN(en1),
        .core_hold(hold1), .done(done1), .err(err1)
    );

    int unsigned depth [2] = '{4096, 4};
    int unsigned base  [2] = '{0, 3};

    logic        in_sess  [2];
    logic        exp_done [2];
    logic        exp_err  [2];
    logic [31:0] last_adr [2];
    logic [31:0] last_dat [2];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [31:0] la [2][64];
    logic [31:0] ld [2][64];
    int          lc [2];
    int          checks = 0;
    int          errors = 0;

    task automatic cmp(int d, string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", nm, d, act, exp);
        end
    endtask

    task automatic cycle_check(int d, logic r, logic w, logic e,
                               logic [31:0] a, logic [31:0] dt,
                               logic h, logic dn, logic er);
        logic [63:0] x;
        cmp(d, "en", 32'(e), 32'(w));
        cmp(d, "s_ready", 32'(r), 32'(in_sess[d] && !w));
        cmp(d, "done", 32'(dn), 32'(exp_done[d]));
        cmp(d, "err", 32'(er), 32'(exp_err[d]));
        cmp(d, "core_hold", 32'(h), 32'(!exp_done[d]));
        if (w) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                cmp(d, "stray_we", 32'(w), 32'd0);
            end else begin
                if (d == 0) x = q0.pop_front();
                else        x = q1.pop_front();
                cmp(d, "wr_adr", a, x[63:32]);
                cmp(d, "wr_data", dt, x[31:0]);
                last_adr[d] = x[63:32];
                last_dat[d] = x[31:0];
            end
            if (lc[d] < 64) begin
                la[d][lc[d]] = a;
                ld[d][lc[d]] = dt;
                lc[d]++;
            end
        end else begin
            cmp(d, "adr_hold", a, last_adr[d]);
            cmp(d, "data_hold", dt, last_dat[d]);
        end
    endtask

    function automatic void model_reset(int d);
        in_sess[d]  = 1'b0;
        exp_done[d] = 1'b0;
        exp_err[d]  = 1'b0;
        last_adr[d] = '0;
        last_dat[d] = '0;
        if (d == 0) q0.delete();
        else        q1.delete();
    endfunction

    task automatic reset_dut(int d);
        rst_n[d] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[d] = 1'b1;
        model_reset(d);
    endtask

    task automatic pulse_start(int d);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic send(int d, logic [7:0] b, int gap);
        logic r;
        int   t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        vld[d]  = 1'b1;
        sdat[d] = b;
        t = 0;
        forever begin
            @(negedge clk);
            r = (d == 0) ? if0.s_ready : if1.s_ready;
            @(posedge clk);
            if (r) break;
            t++;
            if (t > 20) begin
                cmp(d, "ready_timeout", 32'(r), 32'd1);
                break;
            end
        end
        #1;
        vld[d]  = 1'b0;
        sdat[d] = 8'($urandom);
    endtask

    // gaps: 0 none, 1 random, 2 random plus 10-cycle gaps mid-word.
    task automatic run(int d, bq_t st, int gaps, int abort_at);
        int          cnt, n, nb, g;
        logic [7:0]  x;
        logic [31:0] w, a;
        logic        ok;
        cnt = int'({st[1], st[0]});
        n   = (cnt > int'(depth[d])) ? int'(depth[d]) : cnt;
        nb  = 3 + 4 * n;
        x   = '0;
        for (int i = 0; i < nb - 1; i++) x ^= st[i];
        ok = (st[nb-1] == x);
        for (int i = 0; i < n; i++) begin
            w = {st[5+4*i], st[4+4*i], st[3+4*i], st[2+4*i]};
            a = (base[d] + i) % depth[d];
            if (d == 0) q0.push_back({a, w});
            else        q1.push_back({a, w});
        end
        pulse_start(d);
        in_sess[d] = 1'b1;
        exp_err[d] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                reset_dut(d);
                return;
            end
            if (gaps == 0)                          g = 0;
            else if (gaps == 2 && (i == 4 || i == 9)) g = 10;
            else                                    g = $urandom_range(0, 3);
            send(d, st[i], g);
        end
        in_sess[d]  = 1'b0;
        exp_done[d] = ok;
        exp_err[d]  = !ok;
    endtask

    function automatic bq_t rand_stream(int d);
        bq_t        st;
        int         cnt, n;
        logic [7:0] x;
        cnt = (d == 0) ? $urandom_range(0, 6) :
              ($urandom_range(0, 9) + 256 * $urandom_range(0, 1));
        n = (cnt > int'(depth[d])) ? int'(depth[d]) : cnt;
        st.push_back(8'(cnt));
        st.push_back(8'(cnt >> 8));
        for (int i = 0; i < 4 * n; i++) st.push_back(8'($urandom));
        x = '0;
        foreach (st[i]) x ^= st[i];
        if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        st.push_back(x);
        for (int i = 0; i < 4; i++) st.push_back(8'($urandom));
        return st;
    endfunction

    bq_t good, bad, zero, clamp;
    int  b0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            start[d] = 1'b0;
            vld[d]   = 1'b0;
            sdat[d]  = '0;
            lc[d]    = 0;
            model_reset(d);
        end
        good  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        bad   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        zero  = '{8'h00, 8'h00, 8'h00};
        clamp = '{8'h06, 8'h00};
        for (int i = 0; i < 16; i++) clamp.push_back(8'(8'h10 + i));
        clamp.push_back(8'h06);

        fork
            forever begin
                @(negedge clk);
                cycle_check(0, if0.s_ready, we0, en0, 32'(adr0), wd0,
                            hold0, done0, err0);
                cycle_check(1, if1.s_ready, we1, en1, 32'(adr1), wd1,
                            hold1, done1, err1);
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        cmp(0, "reset_hold", 32'(hold0), 32'd1);
        cmp(0, "reset_adr", 32'(adr0), 32'd0);

        run(0, good, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        cmp(0, "basic_n", lc[0], 2);
        cmp(0, "basic_a0", la[0][0], 32'd0);
        cmp(0, "basic_d0", ld[0][0], 32'h0000_0013);
        cmp(0, "basic_a1", la[0][1], 32'd1);
        cmp(0, "basic_d1", ld[0][1], 32'h0010_0093);
        cmp(0, "basic_done", 32'(done0), 32'd1);
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1;
        cmp(0, "done_ignores_start", 32'(done0), 32'd1);

        reset_dut(0);
        b0 = lc[0];
        run(0, zero, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        cmp(0, "zero_writes", lc[0], b0);
        cmp(0, "zero_done", 32'(done0), 32'd1);

        reset_dut(0);
        run(0, bad, 1, -1);
        repeat (2) @(posedge clk);
        #1;
        cmp(0, "bad_err", 32'(err0), 32'd1);
        cmp(0, "bad_hold", 32'(hold0), 32'd1);
        b0 = lc[0];
        run(0, good, 2, -1);
        repeat (2) @(posedge clk);
        #1;
        cmp(0, "reload_d1", ld[0][b0+1], 32'h0010_0093);
        cmp(0, "reload_done", 32'(done0), 32'd1);

        reset_dut(0);
        run(0, good, 1, 4);
        @(negedge clk);
        cmp(0, "midrst_hold", 32'(hold0), 32'd1);
        cmp(0, "midrst_adr", 32'(adr0), 32'd0);
        b0 = lc[0];
        run(0, good, 1, -1);
        repeat (2) @(posedge clk);
        #1;
        cmp(0, "midrst_n", lc[0] - b0, 2);
        cmp(0, "midrst_a0", la[0][b0], 32'd0);
        cmp(0, "midrst_d0", ld[0][b0], 32'h0000_0013);

        run(1, clamp, 1, -1);
        repeat (2) @(posedge clk);
        #1;
        cmp(1, "clamp_n", lc[1], 4);
        cmp(1, "clamp_a0", la[1][0], 32'd3);
        cmp(1, "clamp_a1", la[1][1], 32'd0);
        cmp(1, "clamp_a3", la[1][3], 32'd2);
        cmp(1, "clamp_d0", ld[1][0], 32'h1312_1110);
        cmp(1, "clamp_done", 32'(done1), 32'd1);

        for (int it = 0; it < 16; it++) begin
            int d;
            d = it % 2;
            if (exp_done[d]) reset_dut(d);
            run(d, rand_stream(d), 1, -1);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        cmp(0, "q0_empty", q0.size(), 0);
        cmp(1, "q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
